// File: rtl/mul8_seq.sv
// mul8_seq: sequential 8x8 multiplier built around a single 4x4 multiplier that
//   is time-shared over the four nibble partial products.
// Latency: out_valid rises 4 cycles after the accepting edge; issue interval is 6 cycles.
// Backpressure: p and out_valid hold in DONE until out_ready; in_ready only in IDLE.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand pair a/b presented       in_ready   accepting operands (IDLE)
//   a, b       8-bit multiplicand / multiplier
//   out_valid  p holds a completed product      out_ready  consumer takes p
//   p          16-bit product
//
// Configuration: define MUL8_SEQ_SIGNED_EN for two's-complement operands and
//   product; undefined (default) treats a, b, p as unsigned.

module mul8_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  sc_q, sc_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic        neg_q, neg_d;

  // Operand conditioning at acceptance: STEP always works on magnitudes.
  logic [7:0] a_mag, b_mag;
  logic       neg_in;

`ifdef MUL8_SEQ_SIGNED_EN
  // |-128| = 0x80 fits in 8 unsigned bits, so no extra width is needed.
  assign a_mag  = a[7] ? (~a + 8'd1) : a;
  assign b_mag  = b[7] ? (~b + 8'd1) : b;
  assign neg_in = a[7] ^ b[7];
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign neg_in = 1'b0;
`endif

  // Nibble selection for the shared multiplier, indexed by the step counter.
  logic [3:0]  mx, my;
  logic [7:0]  pp;
  logic [15:0] pp_sh;
  logic [15:0] sum;

  always_comb begin
    mx = a_q[3:0];
    my = b_q[3:0];
    case (sc_q)
      2'd0: begin mx = a_q[3:0]; my = b_q[3:0]; end
      2'd1: begin mx = a_q[7:4]; my = b_q[3:0]; end
      2'd2: begin mx = a_q[3:0]; my = b_q[7:4]; end
      default: begin mx = a_q[7:4]; my = b_q[7:4]; end
    endcase
  end

  // The only multiply in the design: 4x4 -> 8 bits.
  assign pp = {4'b0000, mx} * {4'b0000, my};

  always_comb begin
    pp_sh = {8'h00, pp};
    case (sc_q)
      2'd0:    pp_sh = {8'h00, pp};
      2'd1,
      2'd2:    pp_sh = {4'h0, pp, 4'h0};
      default: pp_sh = {pp, 8'h00};
    endcase
  end

  // Modulo 2^16; the true magnitude product never overflows.
  assign sum = acc_q + pp_sh;

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
          neg_d   = neg_in;
          acc_d   = 16'h0000;
          sc_d    = 2'd0;
          state_d = STEP;
        end
      end
      STEP: begin
        acc_d = sum;
        sc_d  = sc_q + 2'd1;
        if (sc_q == 2'd3) begin
          // Final add and sign fix-up share the same edge, keeping latency at 4.
          if (neg_q) begin
            acc_d = ~sum + 16'd1;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sc_q    <= 2'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      acc_q   <= 16'h0000;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  // p is the accumulator itself; outside DONE it is qualified by out_valid only.
  assign p         = acc_q;

endmodule
